// File: rtl/tpg_timing_gen.sv
// Video timing generator: active-window enables plus HS/VS pulses.
// Optional TPG_TIMING_FRAME_CNT_EN adds frame and active-line counters.
module tpg_timing_gen #(
  parameter int    H_ACTIVE = 1920,
  parameter int    H_FP     = 88,
  parameter int    H_SYNC   = 44,
  parameter int    H_BP     = 148,
  parameter int    V_ACTIVE = 1080,
  parameter int    V_FP     = 4,
  parameter int    V_SYNC   = 5,
  parameter int    V_BP     = 36,
  parameter string HS_POL   = "POS",
  parameter string VS_POL   = "POS"
) (
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic        i_en,
  output logic        o_sync_h,
  output logic        o_sync_v,
  output logic        o_hs,
  output logic        o_vs,
  output logic        o_frame_start
`ifdef TPG_TIMING_FRAME_CNT_EN
  ,
  output logic [15:0] o_frame_cnt,
  output logic [11:0] o_line_active_cnt
`endif
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [11:0] H_LAST = 12'(H_TOTAL - 1);
  localparam logic [11:0] V_LAST = 12'(V_TOTAL - 1);
  localparam logic [11:0] H_ACT  = 12'(H_ACTIVE);
  localparam logic [11:0] V_ACT  = 12'(V_ACTIVE);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic HS_ON = (HS_POL == "NEG") ? 1'b0 : 1'b1;
  localparam logic VS_ON = (VS_POL == "NEG") ? 1'b0 : 1'b1;

  if (H_TOTAL > 4095 || V_TOTAL > 4095) begin : g_bad_total
    $error("tpg_timing_gen: H_TOTAL/V_TOTAL exceed 12-bit counters");
  end
  if (H_FP + H_SYNC + H_BP < 1 || V_FP + V_SYNC + V_BP < 1) begin : g_bad_blank
    $error("tpg_timing_gen: blanking interval must be non-empty");
  end

  typedef enum logic {IDLE, RUN} state_e;

  state_e      state_q, state_d;
  logic [11:0] h_q, h_d;
  logic [11:0] v_q, v_d;
  logic        run_d, sv_d, sh_d, hs_d, vs_d, fs_d;

  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    unique case (state_q)
      IDLE: begin
        if (i_en) begin
          state_d = RUN;
          h_d     = '0;
          v_d     = '0;
        end
      end
      RUN: begin
        if (h_q != H_LAST) begin
          h_d = h_q + 12'd1;
        end else begin
          h_d = '0;
          if (v_q != V_LAST) begin
            v_d = v_q + 12'd1;
          end else begin
            v_d = '0;
            if (!i_en) state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Decode from next-state counters so registered outputs line up with h/v.
  always_comb begin
    run_d = (state_d == RUN);
    sv_d  = run_d && (v_d < V_ACT);
    sh_d  = sv_d && (h_d < H_ACT);
    hs_d  = run_d && (h_d >= HS_BEG) && (h_d < HS_END);
    vs_d  = run_d && (v_d >= VS_BEG) && (v_d < VS_END);
    fs_d  = run_d && (h_d == '0) && (v_d == '0);
  end

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q       <= IDLE;
      h_q           <= '0;
      v_q           <= '0;
      o_sync_h      <= 1'b0;
      o_sync_v      <= 1'b0;
      o_hs          <= ~HS_ON;
      o_vs          <= ~VS_ON;
      o_frame_start <= 1'b0;
    end else begin
      state_q       <= state_d;
      h_q           <= h_d;
      v_q           <= v_d;
      o_sync_h      <= sh_d;
      o_sync_v      <= sv_d;
      o_hs          <= hs_d ? HS_ON : ~HS_ON;
      o_vs          <= vs_d ? VS_ON : ~VS_ON;
      o_frame_start <= fs_d;
    end
  end

`ifdef TPG_TIMING_FRAME_CNT_EN
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_frame_cnt       <= '0;
      o_line_active_cnt <= '0;
    end else begin
      o_frame_cnt       <= o_frame_cnt + 16'(fs_d);
      o_line_active_cnt <= sv_d ? v_d : 12'd0;
    end
  end
`endif

endmodule

// File: tb/tb_tpg_timing_gen.sv
// Randomized bench for tpg_timing_gen against a frame-position model.
// Small POS/NEG instances plus one default 1080p instance.
module tb_tpg_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic en;

  always #5 clk = ~clk;

  logic sh_p, sv_p, hs_p, vs_p, fs_p;
  logic sh_n, sv_n, hs_n, vs_n, fs_n;
  logic sh_d, sv_d, hs_d, vs_d, fs_d;
  logic [4:0] out_p, out_n, out_d;

  assign out_p = {fs_p, sh_p, sv_p, hs_p, vs_p};
  assign out_n = {fs_n, sh_n, sv_n, hs_n, vs_n};
  assign out_d = {fs_d, sh_d, sv_d, hs_d, vs_d};

  tpg_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_pos (
    .i_pclk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_sync_h(sh_p), .o_sync_v(sv_p), .o_hs(hs_p), .o_vs(vs_p),
    .o_frame_start(fs_p)
  );

  tpg_timing_gen #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL("NEG"), .VS_POL("NEG")
  ) u_neg (
    .i_pclk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_sync_h(sh_n), .o_sync_v(sv_n), .o_hs(hs_n), .o_vs(vs_n),
    .o_frame_start(fs_n)
  );

  tpg_timing_gen u_dflt (
    .i_pclk(clk), .i_rst_n(rst_n), .i_en(en),
    .o_sync_h(sh_d), .o_sync_v(sv_d), .o_hs(hs_d), .o_vs(vs_d),
    .o_frame_start(fs_d)
  );

  localparam int S_FRAME = 14 * 7;
  localparam int D_FRAME = 2200 * 1125;

  // Model: linear position within the frame, -1 when idle.
  int pos_s = -1;
  int pos_d = -1;

  function automatic int nxt(int p, int flen, logic e);
    if (p < 0 || p == flen - 1) return e ? 0 : -1;
    return p + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_s <= -1;
      pos_d <= -1;
    end else begin
      pos_s <= nxt(pos_s, S_FRAME, en);
      pos_d <= nxt(pos_d, D_FRAME, en);
    end
  end

  function automatic logic [4:0] exp_out(
    int p, int ha, int hf, int hs, int hb,
    int va, int vf, int vs, int vb, logic neg
  );
    int ht, h, v;
    logic a_sv, a_sh, a_hs, a_vs, a_fs;
    if (p < 0) return {3'b000, neg, neg};
    ht   = ha + hf + hs + hb;
    h    = p % ht;
    v    = p / ht;
    a_sv = (v < va);
    a_sh = a_sv && (h < ha);
    a_hs = (h >= ha + hf) && (h < ha + hf + hs);
    a_vs = (v >= va + vf) && (v < va + vf + vs);
    a_fs = (p == 0);
    return {a_fs, a_sh, a_sv, a_hs ^ neg, a_vs ^ neg};
  endfunction

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("pos_out", 32'(out_p), 32'(exp_out(pos_s, 8, 2, 2, 2, 4, 1, 1, 1, 1'b0)));
    chk("neg_out", 32'(out_n), 32'(exp_out(pos_s, 8, 2, 2, 2, 4, 1, 1, 1, 1'b1)));
    chk("dflt_out", 32'(out_d),
        32'(exp_out(pos_d, 1920, 88, 44, 148, 1080, 4, 5, 36, 1'b0)));
  endtask

  task automatic chk_reset(string tag);
    chk({tag, "_p"}, 32'(out_p), 32'h00);
    chk({tag, "_n"}, 32'(out_n), 32'h03);
    chk({tag, "_d"}, 32'(out_d), 32'h00);
  endtask

  int c_sh, c_sv, c_hs, c_vs, c_fs;
  int guard;

  initial begin
    rst_n = 1'b0;
    en    = 1'b0;
    #12;
    chk_reset("reset");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (50) tick();

    en = 1'b1;
    tick();
    chk("first_fs", 32'(fs_p), 32'd1);
    chk("first_sh", 32'(sh_p), 32'd1);
    c_sh = int'(sh_p); c_sv = int'(sv_p); c_hs = int'(hs_p);
    c_vs = int'(vs_p); c_fs = int'(fs_p);
    for (int i = 1; i < S_FRAME; i++) begin
      tick();
      c_sh += int'(sh_p); c_sv += int'(sv_p); c_hs += int'(hs_p);
      c_vs += int'(vs_p); c_fs += int'(fs_p);
    end
    chk("frame_sh_cnt", 32'(c_sh), 32'd32);
    chk("frame_sv_cnt", 32'(c_sv), 32'd56);
    chk("frame_hs_cnt", 32'(c_hs), 32'd14);
    chk("frame_vs_cnt", 32'(c_vs), 32'd14);
    chk("frame_fs_cnt", 32'(c_fs), 32'd1);
    tick();
    chk("period_fs", 32'(fs_p), 32'd1);

    repeat (30) tick();
    en = 1'b0;
    repeat (S_FRAME - 31) tick();
    chk("last_clk_fs", 32'(fs_p), 32'd0);
    c_fs = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      c_fs += int'(fs_p);
    end
    chk("idle_fs_cnt", 32'(c_fs), 32'd0);

    en = 1'b1;
    guard = 0;
    while (pos_s != 32 && guard < 300) begin
      tick();
      guard++;
    end
    chk("reach_h4v2", 32'(pos_s), 32'd32);
    #1 rst_n = 1'b0;
    #1 chk_reset("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_fs", 32'(fs_p), 32'd1);
    chk("rst_fs_dflt", 32'(fs_d), 32'd1);
    c_sh = int'(sh_d);
    for (int i = 1; i < 2200; i++) begin
      tick();
      c_sh += int'(sh_d);
    end
    chk("dflt_line_sh", 32'(c_sh), 32'd1920);
    tick();
    chk("dflt_line2_sh", 32'(sh_d), 32'd1);

    repeat (3000) begin
      tick();
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0;
        #2 chk_reset("rand_rst");
        rst_n = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
